// File: rtl/pe_arr_pkg.sv
// Shared types, widths and timing helpers for the PE array result path.
package pe_arr_pkg;

  localparam int unsigned ELEM_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } drain_state_e;

  // Width of an element index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n_elem);
    return (n_elem <= 1) ? 1 : $clog2(n_elem);
  endfunction

  // Width of the settle down-counter; wide enough for any k_len.
  function automatic int unsigned cnt_width(input int unsigned kw,
                                            input int unsigned rows,
                                            input int unsigned cols,
                                            input int unsigned lat_scale);
    return kw + $clog2(rows + cols) + $clog2(lat_scale) + 1;
  endfunction

  // Cycles from fire until the last PE output is stable.
  function automatic longint unsigned settle_cycles(input longint unsigned k_len,
                                                    input int unsigned     rows,
                                                    input int unsigned     cols,
                                                    input int unsigned     lat_scale);
    return 64'(lat_scale) * (k_len + 64'(rows) + 64'(cols) - 64'd1);
  endfunction

endpackage

// File: rtl/pe_snap_buf.sv
// Snapshot register for the whole array result bus with an indexed read port.
module pe_snap_buf
  import pe_arr_pkg::*;
#(
  parameter int unsigned NE = 256,
  parameter int unsigned IW = 8
) (
  input  logic                  clk,
  input  logic                  cap_en,
  input  logic [0:ELEM_W*NE-1]  cap_data,
  input  logic [IW-1:0]         rd_idx,
  output logic [ELEM_W-1:0]     rd_data_c
);

  logic [ELEM_W-1:0] snap_q [NE];
  logic [ELEM_W-1:0] snap_d [NE];

  // Load every element from the flat bus when capture is enabled.
  always_comb begin
    snap_d = snap_q;
    if (cap_en) begin
      for (int unsigned e = 0; e < NE; e++) begin
        snap_d[e] = cap_data[ELEM_W*e +: ELEM_W];
      end
    end
  end

  // Snapshot storage; contents are don't-care until the first capture.
  always_ff @(posedge clk) begin
    snap_q <= snap_d;
  end

  // Read mux; indices beyond NE return zero.
  always_comb begin
    rd_data_c = '0;
    for (int unsigned e = 0; e < NE; e++) begin
      if (IW'(e) == rd_idx) rd_data_c = snap_q[e];
    end
  end

endmodule

// File: rtl/pe_drain.sv
// Result drain: waits for the array to settle, snapshots it, streams words out.
module pe_drain
  import pe_arr_pkg::*;
#(
  parameter int unsigned rows      = 16,
  parameter int unsigned cols      = 16,
  parameter int unsigned KW        = 16,
  parameter int unsigned LAT_SCALE = 2
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                start,
  input  logic [KW-1:0]                       k_len,
  input  logic [0:ELEM_W*rows*cols-1]         outs_port,
  output logic [ELEM_W-1:0]                   out_data,
  output logic [idx_width(rows*cols)-1:0]     out_idx,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned NE = rows * cols;
  localparam int unsigned IW = idx_width(NE);
  localparam int unsigned CW = cnt_width(KW, rows, cols, LAT_SCALE);
  localparam logic [IW-1:0] LAST_IDX = IW'(NE - 1);

  drain_state_e      state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [ELEM_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              cap_en_c;
  logic [IW-1:0]     rd_idx_c;
  logic [ELEM_W-1:0] rd_data_c;

  pe_snap_buf #(
    .NE (NE),
    .IW (IW)
  ) u_snap (
    .clk       (clk),
    .cap_en    (cap_en_c),
    .cap_data  (outs_port),
    .rd_idx    (rd_idx_c),
    .rd_data_c (rd_data_c)
  );

  // Next-state and registered-output logic for the drain job.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    cap_en_c    = 1'b0;
    rd_idx_c    = idx_q + IW'(1);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = CW'(settle_cycles(64'(k_len), rows, cols, LAT_SCALE));
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = CAPTURE;
      end
      CAPTURE: begin
        // Word 0 comes straight off the bus since the snapshot loads on this same edge.
        cap_en_c    = 1'b1;
        idx_d       = '0;
        out_data_d  = outs_port[0 +: ELEM_W];
        out_valid_d = 1'b1;
        state_d     = DRAIN;
      end
      DRAIN: begin
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          if (idx_q == LAST_IDX) begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = IDLE;
          end else begin
            idx_d      = rd_idx_c;
            out_data_d = rd_data_c;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_idx   = idx_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
